// File: rtl/spi7001_pkg.sv
// Shared constants and types for the SPI7001 receive monitor: LE command widths,
// FSM states, error flag positions and the scan-line encoder.
package spi7001_pkg;

    localparam logic [7:0] LE_W_DATA  = 8'd1;
    localparam logic [7:0] LE_W_VSYNC = 8'd3;

    localparam logic [7:0] WORD_BITS  = 8'd16;
    // One past the last legal index marks "frame already full".
    localparam logic [7:0] IDX_FULL   = 8'd128;

    localparam int ERR_SHORT    = 0;
    localparam int ERR_LE_WIDTH = 1;
    localparam int ERR_IDX_OVF  = 2;
    localparam int ERR_SCAN     = 3;

    localparam int EDGE_DCLK = 0;
    localparam int EDGE_LE   = 1;
    localparam int EDGE_GCLK = 2;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    function automatic logic [1:0] scan_encode(input logic [3:0] scan);
        logic [1:0] line;
        case (scan)
            4'b0001: line = 2'd0;
            4'b0010: line = 2'd1;
            4'b0100: line = 2'd2;
            4'b1000: line = 2'd3;
            default: line = 2'd0;
        endcase
        return line;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by one edge-detect stage; the delayed level
// and the registered rise/fall pulses are all aligned to the same cycle.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic dly_reg;
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            dly_reg  <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            dly_reg  <= sync_reg;
            rise_reg <= sync_reg & ~dly_reg;
            fall_reg <= ~sync_reg & dly_reg;
        end
    end

    assign level = dly_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/spi7001_rx_monitor.sv
// Passive monitor of an LED-driver serial bus: decodes LE commands into grayscale
// words and vsyncs, counts GCLK per frame and raises sticky protocol error flags.
module spi7001_rx_monitor
    import spi7001_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_dclk,
    input  logic        I_sdi,
    input  logic        I_le,
    input  logic        I_gclk,
    input  logic [3:0]  I_scan,
    input  logic        I_err_clr,
    output logic        O_word_valid,
    output logic [15:0] O_word_data,
    output logic [6:0]  O_word_idx,
    output logic [1:0]  O_word_line,
    output logic        O_vsync,
    output logic [15:0] O_gclk_cnt,
    output logic [3:0]  O_err
);

    logic [2:0] edge_in;
    logic [2:0] edge_lvl;
    logic [2:0] edge_rise;
    logic [2:0] edge_fall;

    assign edge_in[EDGE_DCLK] = I_dclk;
    assign edge_in[EDGE_LE]   = I_le;
    assign edge_in[EDGE_GCLK] = I_gclk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        sync_edge u_sync (
            .clk   (I_clk),
            .rst_n (I_rst_n),
            .din   (edge_in[gi]),
            .level (edge_lvl[gi]),
            .rise  (edge_rise[gi]),
            .fall  (edge_fall[gi])
        );
    end

    logic dclk_rise;
    logic le_lvl;
    logic le_fall;
    logic gclk_rise;
    logic unused_edges;

    assign dclk_rise    = edge_rise[EDGE_DCLK];
    assign le_lvl       = edge_lvl[EDGE_LE];
    assign le_fall      = edge_fall[EDGE_LE];
    assign gclk_rise    = edge_rise[EDGE_GCLK];
    assign unused_edges = ^{edge_lvl[EDGE_DCLK], edge_lvl[EDGE_GCLK], edge_rise[EDGE_LE],
                            edge_fall[EDGE_DCLK], edge_fall[EDGE_GCLK]};

    // SDI and scan take the same three-register depth so they line up with the pulses.
    logic [4:0] data_meta_reg;
    logic [4:0] data_sync_reg;
    logic [4:0] data_dly_reg;
    logic       sdi_d;
    logic [3:0] scan_d;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            data_meta_reg <= '0;
            data_sync_reg <= '0;
            data_dly_reg  <= '0;
        end else begin
            data_meta_reg <= {I_scan, I_sdi};
            data_sync_reg <= data_meta_reg;
            data_dly_reg  <= data_sync_reg;
        end
    end

    assign sdi_d  = data_dly_reg[0];
    assign scan_d = data_dly_reg[4:1];

    // Shift / count stage; an LE fall snapshots everything into the cmd_* registers.
    logic [15:0] shift_reg;
    logic [15:0] shift_next;
    logic [7:0]  bit_cnt_reg;
    logic [7:0]  bit_cnt_next;
    logic [7:0]  le_width_reg;
    logic        cmd_word_reg;
    logic        cmd_vsync_reg;
    logic        cmd_bad_reg;
    logic        cmd_short_reg;
    logic [15:0] cmd_data_reg;
    logic [3:0]  cmd_scan_reg;

    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        if (dclk_rise) begin
            shift_next = {shift_reg[14:0], sdi_d};
            if (bit_cnt_reg != 8'hFF) begin
                bit_cnt_next = bit_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            le_width_reg  <= '0;
            cmd_word_reg  <= 1'b0;
            cmd_vsync_reg <= 1'b0;
            cmd_bad_reg   <= 1'b0;
            cmd_short_reg <= 1'b0;
            cmd_data_reg  <= '0;
            cmd_scan_reg  <= '0;
        end else begin
            shift_reg     <= shift_next;
            cmd_word_reg  <= 1'b0;
            cmd_vsync_reg <= 1'b0;
            cmd_bad_reg   <= 1'b0;
            if (le_fall) begin
                // A coincident DCLK bit joins the word but not the LE width.
                cmd_word_reg  <= (le_width_reg == LE_W_DATA);
                cmd_vsync_reg <= (le_width_reg == LE_W_VSYNC);
                cmd_bad_reg   <= (le_width_reg != LE_W_DATA) && (le_width_reg != LE_W_VSYNC);
                cmd_data_reg  <= shift_next;
                cmd_short_reg <= (bit_cnt_next < WORD_BITS);
                cmd_scan_reg  <= scan_d;
                bit_cnt_reg   <= '0;
                le_width_reg  <= '0;
            end else begin
                bit_cnt_reg <= bit_cnt_next;
                if (dclk_rise && le_lvl && (le_width_reg != 8'hFF)) begin
                    le_width_reg <= le_width_reg + 8'd1;
                end
            end
        end
    end

    state_t state_reg;
    state_t state_next;
    logic   word_take;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg <= WAIT_SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        word_take  = 1'b0;
        case (state_reg)
            WAIT_SYNC: if (cmd_vsync_reg) state_next = RUN;
            RUN:       word_take = cmd_word_reg;
        endcase
    end

    logic [7:0]  idx_cnt_reg;
    logic [15:0] gclk_cnt_reg;
    logic [3:0]  err_set;
    logic [3:0]  err_next;

    always_comb begin
        err_set               = '0;
        err_set[ERR_LE_WIDTH] = cmd_bad_reg;
        if (word_take) begin
            err_set[ERR_SHORT]   = cmd_short_reg;
            err_set[ERR_IDX_OVF] = (idx_cnt_reg == IDX_FULL);
            err_set[ERR_SCAN]    = !$onehot(cmd_scan_reg);
        end
        err_next = (I_err_clr ? 4'b0000 : O_err) | err_set;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            idx_cnt_reg  <= '0;
            gclk_cnt_reg <= '0;
            O_word_valid <= 1'b0;
            O_word_data  <= '0;
            O_word_idx   <= '0;
            O_word_line  <= '0;
            O_vsync      <= 1'b0;
            O_gclk_cnt   <= '0;
            O_err        <= '0;
        end else begin
            O_word_valid <= word_take;
            O_vsync      <= cmd_vsync_reg;
            O_err        <= err_next;
            if (word_take) begin
                O_word_data <= cmd_data_reg;
                O_word_idx  <= idx_cnt_reg[7] ? 7'd127 : idx_cnt_reg[6:0];
                O_word_line <= scan_encode(cmd_scan_reg);
            end
            if (cmd_vsync_reg) begin
                idx_cnt_reg <= '0;
            end else if (word_take && (idx_cnt_reg != IDX_FULL)) begin
                idx_cnt_reg <= idx_cnt_reg + 8'd1;
            end
            // An edge landing on the vsync cycle belongs to the new frame.
            if (cmd_vsync_reg) begin
                O_gclk_cnt   <= gclk_cnt_reg;
                gclk_cnt_reg <= {15'd0, gclk_rise};
            end else if (gclk_rise && (gclk_cnt_reg != 16'hFFFF)) begin
                gclk_cnt_reg <= gclk_cnt_reg + 16'd1;
            end
        end
    end

endmodule
